// File: rtl/cdc_hs_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cdc_hs_pkg
// Brief    : Shared types and defaults for the four-phase req/ack CDC pair.
// Revision : 1.0 - initial release
// ============================================================================
package cdc_hs_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        REL  = 2'd2
    } cdc_hs_state_e;

    localparam int CDC_HS_STAGE_DEF   = 2;
    localparam int CDC_HS_TIMEOUT_DEF = 1024;

endpackage
`default_nettype wire

// File: rtl/cdc_hs_ack_sync.sv
`default_nettype none
// ============================================================================
// Module   : cdc_hs_ack_sync
// Brief    : STAGE-deep flop chain bringing the asynchronous ack into clk_i.
// Revision : 1.0 - initial release
// ============================================================================
module cdc_hs_ack_sync
    import cdc_hs_pkg::*;
#(
    parameter int STAGE = CDC_HS_STAGE_DEF
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic ack_i,
    output logic ack_s
);

    logic [STAGE-1:0] r_sync;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[STAGE-2:0], ack_i};
        end
    end

    assign ack_s = r_sync[STAGE-1];

endmodule
`default_nettype wire

// File: rtl/cdc_hs_src.sv
`default_nettype none
// ============================================================================
// Module   : cdc_hs_src
// Brief    : Source side of a four-phase req/ack word transfer. Define
//            CDC_HS_TIMEOUT_EN to add per-phase timeouts and a sticky err_o.
// Revision : 1.0 - initial release
// ============================================================================
module cdc_hs_src
    import cdc_hs_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int STAGE       = CDC_HS_STAGE_DEF,
    parameter int TIMEOUT_CYC = CDC_HS_TIMEOUT_DEF
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic [DATA_WIDTH-1:0] dat_i,
    output logic                  req_o,
    output logic [DATA_WIDTH-1:0] dat_o,
    input  logic                  ack_i,
    output logic                  busy_o,
    output logic                  err_o
);

    generate
        if (STAGE < 2) begin : g_stage_check
            $error("cdc_hs_src: STAGE must be at least 2");
        end
        if (TIMEOUT_CYC < STAGE + 2) begin : g_timeout_check
            $error("cdc_hs_src: TIMEOUT_CYC must be at least STAGE+2");
        end
    endgenerate

    cdc_hs_state_e r_state;
    cdc_hs_state_e w_state_nxt;
    logic          w_ack_s;
    logic          w_accept;
    logic          w_timeout;

    cdc_hs_ack_sync #(
        .STAGE (STAGE)
    ) u_ack_sync (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .ack_i (ack_i),
        .ack_s (w_ack_s)
    );

    // A stale ack still high in IDLE blocks new words until the destination releases it.
    assign w_accept = (r_state == IDLE) && valid_i && !w_ack_s;

`ifdef CDC_HS_TIMEOUT_EN
    localparam int              c_CNT_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT_CYC - 1);

    logic [c_CNT_W-1:0] r_cnt;
    logic               r_err;

    // Timeout only counts as an error if the phase's awaited ack level never arrived.
    assign w_timeout = (r_state != IDLE) && (r_cnt == c_CNT_LAST) &&
                       (w_ack_s == (r_state == REL));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cnt <= '0;
            r_err <= 1'b0;
        end else begin
            if (w_state_nxt != r_state) begin
                r_cnt <= '0;
            end else if (r_state != IDLE) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_accept) begin
                r_err <= 1'b0;
            end else if (w_timeout) begin
                r_err <= 1'b1;
            end
        end
    end

    assign err_o = r_err;
`else
    assign w_timeout = 1'b0;
    assign err_o     = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= IDLE;
            req_o   <= 1'b0;
            dat_o   <= '0;
        end else begin
            r_state <= w_state_nxt;
            req_o   <= (w_state_nxt == REQ);
            if (w_accept) begin
                dat_o <= dat_i;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept)              w_state_nxt = REQ;
            REQ:     if (w_ack_s || w_timeout)  w_state_nxt = REL;
            REL:     if (!w_ack_s || w_timeout) w_state_nxt = IDLE;
            default:                            w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ready_o = (r_state == IDLE) && !w_ack_s;
        busy_o  = (r_state != IDLE);
    end

endmodule
`default_nettype wire
